bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the processor's single system bus between NUM_MASTERS requesters: instruction fetch, data access, and optional DMA/debug.
- Sits between the masters and the bus multiplexer. Drives a one-hot grant and an encoded owner index that selects the address, data and control mux.
- Provides a hold limit with preemption so that no master can starve the others.

---
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a mandatory turnaround cycle between owners
// and a hold limit that preempts a long-running owner when others are waiting.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   bus_busy,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [OWNER_W-1:0]     owner,
    output logic                   bus_valid,
    output logic                   preempted,
    output logic [1:0]             dbg_state
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        TURN    = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic [OWNER_W-1:0]     owner_n;
    logic [OWNER_W-1:0]     last, last_n;
    logic [HOLD_W-1:0]      hold, hold_n;
    logic                   pre_n;

    logic [OWNER_W-1:0]     sel;
    logic                   sel_found;
    int                     idx;
    logic                   other_req;
    logic                   preempt_fire;

    // First requester scanning upward from last+1, wrapping.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last) + i) % NUM_MASTERS;
            if (!sel_found && req[idx[OWNER_W-1:0]]) begin
                sel_found = 1'b1;
                sel       = idx[OWNER_W-1:0];
            end
        end
    end

    assign other_req    = |(req & ~grant);
    assign preempt_fire = (MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD))
                          && other_req && !bus_busy;

    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold;
        pre_n   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n = GRANTED;
                    grant_n = NUM_MASTERS'(1) << sel;
                    owner_n = sel;
                    hold_n  = HOLD_W'(1);
                end
            end
            GRANTED: begin
                // A release on the same cycle as a preemption is a plain release.
                if (!req[owner]) begin
                    state_n = TURN;
                    grant_n = '0;
                    last_n  = owner;
                    hold_n  = '0;
                end else if (preempt_fire) begin
                    state_n = TURN;
                    grant_n = '0;
                    last_n  = owner;
                    hold_n  = '0;
                    pre_n   = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold != HOLD_W'(MAX_HOLD))) begin
                    hold_n = hold + HOLD_W'(1);
                end
            end
            TURN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            last      <= OWNER_W'(NUM_MASTERS - 1);
            hold      <= '0;
            preempted <= 1'b0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            owner     <= owner_n;
            last      <= last_n;
            hold      <= hold_n;
            preempted <= pre_n;
        end
    end

    assign bus_valid = |grant;
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int OW = 2;
    localparam int MH = 16;

    logic          clk = 1'b0;
    logic          reset_;
    logic [N-1:0]  req;
    logic          bus_busy;
    logic [N-1:0]  grant;
    logic [OW-1:0] owner;
    logic          bus_valid;
    logic          preempted;
    logic [1:0]    dbg_state;

    int tests = 0;
    int fails = 0;

    bus_arbiter #(.NUM_MASTERS(N), .OWNER_W(OW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req),
        .bus_busy  (bus_busy),
        .grant     (grant),
        .owner     (owner),
        .bus_valid (bus_valid),
        .preempted (preempted),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the bus, how long, and how many dead cycles remain.
    bit           m_active;
    int           m_owner;
    int           m_shown;
    int           m_held;
    int           m_gap;
    int           m_last;
    bit           m_pre;
    logic [N-1:0] m_others;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_active = 0;
            m_owner  = 0;
            m_shown  = 0;
            m_held   = 0;
            m_gap    = 0;
            m_last   = N - 1;
            m_pre    = 0;
        end else begin
            m_pre = 0;
            if (m_active) begin
                m_others = req & ~(N'(1) << m_owner);
                if (!req[m_owner]) begin
                    m_active = 0; m_last = m_owner; m_gap = 1;
                end else if (MH > 0 && m_held >= MH && m_others != 0 && !bus_busy) begin
                    m_active = 0; m_last = m_owner; m_gap = 1; m_pre = 1;
                end else begin
                    m_held++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    if (!m_active && req[(m_last + i) % N]) begin
                        m_active = 1;
                        m_owner  = (m_last + i) % N;
                        m_shown  = m_owner;
                        m_held   = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model plus the grant invariants.
    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (reset_) begin
            eg = m_active ? (N'(1) << m_owner) : '0;
            check("model_grant", 32'(grant), 32'(eg));
            check("model_owner", 32'(owner), 32'(m_shown));
            check("model_valid", 32'(bus_valid), 32'(eg != 0));
            check("model_preempted", 32'(preempted), 32'(m_pre));
            check("onehot0", 32'($onehot0(grant)), 32'd1);
            check("no_direct_switch",
                  32'(prev_grant != 0 && grant != 0 && prev_grant != grant), 32'd0);
            prev_grant = grant;
        end else begin
            prev_grant = '0;
        end
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int seen[$];
        int cnt, gap;
        logic [N-1:0] prev;

        reset_ = 1'b0; req = '0; bus_busy = 1'b0;
        #12;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_owner", 32'(owner), 32'd0);
        check("reset_valid", 32'(bus_valid), 32'd0);
        check("reset_preempted", 32'(preempted), 32'd0);
        #8 reset_ = 1'b1;

        // Single request: 8 granted cycles, then turnaround.
        @(negedge clk);
        check("idle_grant", 32'(grant), 32'd0);
        req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_grant", 32'(grant), 32'b0001);
            check("t1_owner", 32'(owner), 32'd0);
            if (k == 8) req = 4'b0000;
        end
        @(negedge clk);
        check("t1_turn", 32'(grant), 32'd0);
        @(negedge clk);
        check("t1_idle", 32'(grant), 32'd0);

        // Restart from master-0 priority, then round robin with req=1111.
        @(negedge clk); #2 reset_ = 1'b0;
        @(negedge clk); reset_ = 1'b1;
        req = 4'b1111; cnt = 0; gap = 0; prev = '0;
        for (int c = 0; c < 80 && seen.size() < 5; c++) begin
            @(negedge clk);
            if (grant != 0) begin
                if (prev == 0) begin
                    seen.push_back(int'(owner));
                    if (seen.size() > 1) check("rr_gap", 32'(gap), 32'd2);
                    cnt = 0;
                end
                cnt++;
                if (cnt == 3) req[owner] = 1'b0;
            end else begin
                if (prev != 0) begin
                    check("rr_len", 32'(cnt), 32'd3);
                    gap = 0;
                end
                gap++;
                req = 4'b1111;
            end
            prev = grant;
        end
        check("rr_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size() && i < 5; i++)
            check("rr_order", 32'(seen[i]), 32'(i % 4));
        req = '0;
        wait_neg(4);

        // Preemption after the 16th granted cycle.
        req = 4'b0010;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("t3_hold", 32'(grant), 32'b0010);
            check("t3_nopre", 32'(preempted), 32'd0);
            if (k == 5) req = 4'b0110;
        end
        @(negedge clk);
        check("t3_drop", 32'(grant), 32'd0);
        check("t3_pre", 32'(preempted), 32'd1);
        @(negedge clk);
        check("t3_gap", 32'(grant), 32'd0);
        check("t3_pre_pulse", 32'(preempted), 32'd0);
        @(negedge clk);
        check("t3_next", 32'(grant), 32'b0100);
        check("t3_owner", 32'(owner), 32'd2);
        req = '0;
        wait_neg(4);

        // Preemption held off by bus_busy until it falls.
        req = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("t4_hold", 32'(grant), 32'b0010);
            check("t4_nopre", 32'(preempted), 32'd0);
            if (k == 5)  req = 4'b0110;
            if (k == 14) bus_busy = 1'b1;
            if (k == 20) bus_busy = 1'b0;
        end
        @(negedge clk);
        check("t4_drop", 32'(grant), 32'd0);
        check("t4_pre", 32'(preempted), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t4_next", 32'(grant), 32'b0100);
        req = '0;
        wait_neg(4);

        // Release on the 16th cycle with master 3 waiting: no preemption.
        req = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("t5_hold", 32'(grant), 32'b0001);
            if (k == 2)  req = 4'b1001;
            if (k == 16) req = 4'b1000;
        end
        @(negedge clk);
        check("t5_drop", 32'(grant), 32'd0);
        check("t5_nopre", 32'(preempted), 32'd0);
        @(negedge clk);
        check("t5_nopre2", 32'(preempted), 32'd0);
        @(negedge clk);
        check("t5_next", 32'(grant), 32'b1000);
        check("t5_owner", 32'(owner), 32'd3);

        // Asynchronous reset between edges while master 3 owns the bus.
        @(negedge clk); #2 reset_ = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_valid", 32'(bus_valid), 32'd0);
        req = 4'b1001;
        @(negedge clk); reset_ = 1'b1;
        @(negedge clk);
        check("t6_first", 32'(grant), 32'b0001);
        check("t6_owner", 32'(owner), 32'd0);
        req = '0;
        wait_neg(4);

        // Randomized traffic with occasional mid-run resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 19) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 5) == 0) bus_busy = ~bus_busy;
            if ($urandom_range(0, 799) == 0) begin
                #2 reset_ = 1'b0;
                #1 check("rand_async_grant", 32'(grant), 32'd0);
                @(negedge clk); reset_ = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
